// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// reset/step defaults and the word-alignment mask for branch targets.
package ifetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned STEP_DEF     = 4;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, loads d
// when load is high, otherwise holds.
module ifetch_pc_reg #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: req/ack word reads at the current PC, registered
// instruction/PC handoff to decode, stall hold and branch redirect.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       STEP     = STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] MASK_W = ~ADDR_W'(~ALIGN_MASK);

  state_t            state_q, state_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] instr_d, instr_pc_d;
  logic              valid_d;
  logic              pc_load;
  logic [ADDR_W-1:0] pc, pc_d, target;

  assign target    = br_target & MASK_W;
  assign imem_addr = pc;

  ifetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      pend_q      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      pend_q      <= pend_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= valid_d;
    end
  end

  // A redirect during an outstanding read is parked in pend_q so the address
  // stays stable until memory acks; the stale data is then dropped.
  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    pend_d     = pend_q;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    valid_d    = instr_valid;
    pc_load    = 1'b0;
    pc_d       = pc + STEP_W;
    imem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (br_taken) begin
          pc_load = 1'b1;
          pc_d    = target;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (br_taken) begin
            pc_load   = 1'b1;
            pc_d      = target;
            discard_d = 1'b0;
          end else if (discard_q) begin
            pc_load   = 1'b1;
            pc_d      = pend_q;
            discard_d = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
            pc_load    = 1'b1;
            valid_d    = 1'b1;
            state_d    = OUT;
          end
        end else if (br_taken) begin
          pend_d    = target;
          discard_d = 1'b1;
        end
      end
      OUT: begin
        if (br_taken) begin
          valid_d = 1'b0;
          pc_load = 1'b1;
          pc_d    = target;
          state_d = REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: table of fetch scenarios plus hand sequences for
// branch, stall, wrap-around and mid-request reset.
module tb_ifetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem_addr, instr, instr_pc;
  logic        imem_req, instr_valid;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;

  logic [31:0] addr2, instr2, instr_pc2;
  logic        req2, valid2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        br2 = 1'b0;
  logic [31:0] tgt2 = '0;
  logic        stall2 = 1'b0;

  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .br_taken(br_taken),
    .br_target(br_target), .stall(stall), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid)
  );

  ifetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr2), .imem_req(req2),
    .imem_ack(ack2), .imem_rdata(rdata2), .br_taken(br2),
    .br_target(tgt2), .stall(stall2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(valid2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_cyc = -10;
  int ack_delay = 0;
  int cnt = 0;
  bit busy = 1'b0;
  bit busy2 = 1'b0;
  logic [31:0] cap = '0;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  typedef struct { int delay; int stall_cyc; logic [31:0] pc; } vec_t;
  vec_t tbl[7];
  int acc[7];

  logic [31:0] exp2[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  int k2 = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory: request seen at one negedge, ack at least one cycle later.
  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (rst_n && imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = 0;
        cap  = imem_addr;
      end else begin
        check("addr_stable", imem_addr, cap);
        if (cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ KEY;
          busy       = 1'b0;
          ack_cyc    = cyc;
        end else begin
          cnt++;
        end
      end
    end else begin
      busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    ack2 = 1'b0;
    if (rst_n && req2) begin
      if (!busy2) begin
        busy2 = 1'b1;
      end else begin
        ack2   = 1'b1;
        rdata2 = addr2 ^ KEY;
        busy2  = 1'b0;
      end
    end else begin
      busy2 = 1'b0;
    end
  end

  // Scoreboard: pop on every accepted instruction.
  always @(negedge clk) begin
    #2;
    if (instr_valid && !prev_valid) check("ack_to_valid", cyc, ack_cyc + 1);
    prev_valid = instr_valid;
    if (instr_valid && !stall) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL accept: unexpected instr_pc %h required none", instr_pc);
      end else begin
        e_mon = sb.pop_front();
        check("instr_pc", instr_pc, e_mon.pc);
        check("instr", instr, e_mon.data);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (valid2 && k2 < 3) begin
      check("wrap_pc", instr_pc2, exp2[k2]);
      check("wrap_instr", instr2, exp2[k2] ^ KEY);
      k2++;
    end
  end

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!instr_valid && n < 100);
    if (!instr_valid) begin
      total++;
      bad++;
      $display("FAIL %s: instr_valid got 0 required 1 within 100 cycles", name);
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!imem_req && n < 100);
    if (!imem_req) begin
      total++;
      bad++;
      $display("FAIL %s: imem_req got 0 required 1 within 100 cycles", name);
    end
  endtask

  initial begin
    logic [31:0] h_i, h_p;
    tbl[0] = '{0, 0, 32'h0000_0000};
    tbl[1] = '{0, 0, 32'h0000_0004};
    tbl[2] = '{0, 0, 32'h0000_0008};
    tbl[3] = '{3, 0, 32'h0000_000C};
    tbl[4] = '{0, 5, 32'h0000_0010};
    tbl[5] = '{0, 0, 32'h0000_0014};
    tbl[6] = '{2, 0, 32'h0000_0018};

    #3;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_addr", imem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      ack_delay = tbl[i].delay;
      stall = (tbl[i].stall_cyc > 0);
      sb.push_back('{tbl[i].pc, tbl[i].pc ^ KEY});
      wait_valid("row_valid");
      acc[i] = cyc;
      if (stall) begin
        h_i = instr;
        h_p = instr_pc;
        for (int k = 0; k < tbl[i].stall_cyc; k++) begin
          @(negedge clk); #1;
          check("stall_valid", instr_valid, 1);
          check("stall_instr", instr, h_i);
          check("stall_instr_pc", instr_pc, h_p);
          check("stall_noreq", imem_req, 0);
          check("stall_addr", imem_addr, h_p + 32'd4);
        end
        stall = 1'b0;
      end
    end
    check("tput_1", acc[1] - acc[0], 3);
    check("tput_2", acc[2] - acc[1], 3);

    // Redirect while a slow read is outstanding.
    ack_delay = 2;
    wait_req("br_req");
    check("pre_br_addr", imem_addr, 32'h0000_001C);
    br_target = 32'h0000_1003;
    br_taken = 1'b1;
    @(negedge clk); #1;
    br_taken = 1'b0;
    check("br_hold_addr", imem_addr, 32'h0000_001C);
    check("br_hold_req", imem_req, 1);
    sb.push_back('{32'h0000_1000, 32'h0000_1000 ^ KEY});
    wait_valid("br_valid");

    // Redirect in OUT overrides stall.
    @(negedge clk); #1;
    ack_delay = 0;
    stall = 1'b1;
    wait_valid("out_valid");
    check("out_pc", instr_pc, 32'h0000_1004);
    br_target = 32'h0000_2002;
    br_taken = 1'b1;
    @(negedge clk); #1;
    br_taken = 1'b0;
    stall = 1'b0;
    check("br_out_valid", instr_valid, 0);
    check("br_out_req", imem_req, 1);
    check("br_out_addr", imem_addr, 32'h0000_2000);
    sb.push_back('{32'h0000_2000, 32'h0000_2000 ^ KEY});
    wait_valid("br2_valid");

    // Asynchronous reset with a request outstanding.
    ack_delay = 5;
    wait_req("rst_req_wait");
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_instr", instr, 0);
    check("arst_instr_pc", instr_pc, 0);
    check("arst_addr", imem_addr, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    ack_delay = 0;
    sb.push_back('{32'h0000_0000, 32'h0000_0000 ^ KEY});
    wait_valid("post_rst_valid");

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("wrap_count", k2, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
